// File: rtl/wb_grf_if.sv
// Bus bundle between the M/W pipeline register, the D-stage readers and wb_grf.
// master drives the W-stage inputs and read addresses; slave is the register file.
interface wb_grf_if #(
    parameter int CNT_W = 32
);
    logic [31:0]      W_PC8;
    logic [2:0]       W_RegWrite;
    logic [2:0]       W_RegWriteSel;
    logic [31:0]      W_LoadData;
    logic [31:0]      W_ALURe;
    logic [4:0]       W_A3;
    logic [4:0]       D_A1;
    logic [4:0]       D_A2;
    logic [31:0]      D_RD1;
    logic [31:0]      D_RD2;
    logic [31:0]      W_WD;
    logic             W_WE;
    logic [4:0]       W_FwdA3;
    logic [CNT_W-1:0] commit_cnt;

    modport master (
        output W_PC8, W_RegWrite, W_RegWriteSel, W_LoadData, W_ALURe, W_A3, D_A1, D_A2,
        input  D_RD1, D_RD2, W_WD, W_WE, W_FwdA3, commit_cnt
    );

    modport slave (
        input  W_PC8, W_RegWrite, W_RegWriteSel, W_LoadData, W_ALURe, W_A3, D_A1, D_A2,
        output D_RD1, D_RD2, W_WD, W_WE, W_FwdA3, commit_cnt
    );
endinterface

// File: rtl/wb_grf.sv
// Writeback mux, 32x32 register file with two combinational read ports and a commit counter.
// Define WB_GRF_BYPASS_EN to return the in-flight writeback value on a same-cycle read.
module wb_grf #(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic     clk,
    input  logic     reset,
    wb_grf_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      grf [1:NREG-1];
    logic [CNT_W-1:0] cnt;
    logic [31:0]      wd;
    logic             we;
    logic [31:0]      rd1;
    logic [31:0]      rd2;

    always_comb begin
        case (bus.W_RegWriteSel)
            3'd0:    wd = bus.W_ALURe;
            3'd1:    wd = bus.W_LoadData;
            3'd2:    wd = bus.W_PC8;
            default: wd = 32'h0;
        endcase
    end

    assign we = (bus.W_RegWrite != 3'd0) && (bus.W_A3 != 5'd0) && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < NREG; i++) grf[i] <= 32'h0;
            cnt <= '0;
        end else if (we) begin
            grf[bus.W_A3] <= wd;
            cnt           <= cnt + CNT_ONE;
        end
    end

    always_comb begin
        rd1 = (bus.D_A1 == 5'd0) ? 32'h0 : grf[bus.D_A1];
        rd2 = (bus.D_A2 == 5'd0) ? 32'h0 : grf[bus.D_A2];
`ifdef WB_GRF_BYPASS_EN
        // we already excludes $0, so the zero register can never take the bypass
        if (we && (bus.D_A1 == bus.W_A3)) rd1 = wd;
        if (we && (bus.D_A2 == bus.W_A3)) rd2 = wd;
`endif
    end

    assign bus.D_RD1      = rd1;
    assign bus.D_RD2      = rd2;
    assign bus.W_WD       = wd;
    assign bus.W_WE       = we;
    assign bus.W_FwdA3    = we ? bus.W_A3 : 5'd0;
    assign bus.commit_cnt = cnt;
endmodule

// File: tb/tb_wb_grf.sv
// Scoreboard bench for wb_grf: stimulus pushes expected outputs from an array model,
// a negedge monitor pops and compares.
module tb_wb_grf;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    wb_grf_if #(.CNT_W(32)) bus ();

    wb_grf #(.NREG(32), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef WB_GRF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] wd;
        logic        we;
        logic [4:0]  fwd;
        logic [31:0] cnt;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mrf [32];
    logic [31:0] mcnt;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;

    function automatic logic [31:0] ref_read(input logic [4:0] a, input logic w,
                                             input logic [4:0] a3, input logic [31:0] v);
        if (a == 5'd0) return 32'h0;
        if (BYP && w && a == a3) return v;
        return mrf[a];
    endfunction

    task automatic step(input logic rst, input logic [2:0] rw, input logic [2:0] sel,
                        input logic [31:0] alu, input logic [31:0] ld, input logic [31:0] pc8,
                        input logic [4:0] a3, input logic [4:0] a1, input logic [4:0] a2);
        exp_t        e;
        logic [31:0] v;
        logic        w;
        @(posedge clk);
        #1;
        reset             = rst;
        bus.W_RegWrite    = rw;
        bus.W_RegWriteSel = sel;
        bus.W_ALURe       = alu;
        bus.W_LoadData    = ld;
        bus.W_PC8         = pc8;
        bus.W_A3          = a3;
        bus.D_A1          = a1;
        bus.D_A2          = a2;
        v = (sel == 3'd0) ? alu : (sel == 3'd1) ? ld : (sel == 3'd2) ? pc8 : 32'h0;
        w = (rw != 3'd0) && (a3 != 5'd0) && !rst;
        e.cyc = cyc;
        e.rd1 = ref_read(a1, w, a3, v);
        e.rd2 = ref_read(a2, w, a3, v);
        e.wd  = v;
        e.we  = w;
        e.fwd = w ? a3 : 5'd0;
        e.cnt = mcnt;
        sb.push_back(e);
        // model state as it will be after the coming edge
        if (rst) begin
            foreach (mrf[i]) mrf[i] = 32'h0;
            mcnt = 32'h0;
        end else if (w) begin
            mrf[a3] = v;
            mcnt    = mcnt + 32'd1;
        end
        cyc++;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v,
                       input int c);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp_v);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd1",  bus.D_RD1,                 e.rd1,                 e.cyc);
                chk("rd2",  bus.D_RD2,                 e.rd2,                 e.cyc);
                chk("wd",   bus.W_WD,                  e.wd,                  e.cyc);
                chk("we",   {31'h0, bus.W_WE},         {31'h0, e.we},         e.cyc);
                chk("fwd",  {27'h0, bus.W_FwdA3},      {27'h0, e.fwd},        e.cyc);
                chk("cnt",  bus.commit_cnt,            e.cnt,                 e.cyc);
            end
        end
    end

    initial begin : stim
        logic        rst;
        logic [2:0]  rw;
        logic [4:0]  a3;
        logic [4:0]  a1;
        logic [4:0]  a2;
        int          waited;
        reset             = 1'b1;
        bus.W_RegWrite    = 3'd0;
        bus.W_RegWriteSel = 3'd0;
        bus.W_ALURe       = 32'h0;
        bus.W_LoadData    = 32'h0;
        bus.W_PC8         = 32'h0;
        bus.W_A3          = 5'd0;
        bus.D_A1          = 5'd0;
        bus.D_A2          = 5'd0;
        repeat (2) @(posedge clk);
        foreach (mrf[i]) mrf[i] = 32'h0;
        mcnt = 32'h0;

        // reset still held with a write presented: W_WE must stay low
        step(1'b1, 3'd1, 3'd0, 32'hCAFE_0001, 32'h0, 32'h0, 5'd8, 5'd8, 5'd0);
        for (int i = 0; i < 32; i++)
            step(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'(i), 5'(31 - i));

        step(1'b0, 3'd1, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 5'd8, 5'd0, 5'd0);
        step(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd0);
        step(1'b0, 3'd1, 3'd1, 32'h0, 32'hFFFF_FF80, 32'h0, 5'd9, 5'd0, 5'd0);
        step(1'b0, 3'd1, 3'd2, 32'h0, 32'h0, 32'h0000_3008, 5'd31, 5'd0, 5'd9);
        step(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd8, 5'd31);

        step(1'b0, 3'd1, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);

        step(1'b0, 3'd1, 3'd0, 32'h0000_0007, 32'h0, 32'h0, 5'd5, 5'd0, 5'd0);
        step(1'b0, 3'd1, 3'd0, 32'hAAAA_0001, 32'h0, 32'h0, 5'd5, 5'd5, 5'd5);
        step(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);

        step(1'b0, 3'd1, 3'd0, 32'h55, 32'h0, 32'h0, 5'd3, 5'd0, 5'd0);
        step(1'b1, 3'd1, 3'd0, 32'h66, 32'h0, 32'h0, 5'd4, 5'd3, 5'd4);
        step(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd3, 5'd4);

        step(1'b0, 3'd1, 3'd0, 32'h0000_0042, 32'h0, 32'h0, 5'd7, 5'd0, 5'd0);
        step(1'b0, 3'd0, 3'd0, 32'h99, 32'h0, 32'h0, 5'd7, 5'd7, 5'd7);
        step(1'b0, 3'd0, 3'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd7, 5'd7);

        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            rw  = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            a3  = 5'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
            a2  = ($urandom_range(0, 2) == 0) ? a3 : 5'($urandom_range(0, 31));
            step(rst, rw, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, a3, a1, a2);
        end

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
